// File: rtl/core_ex_muldiv_if.sv
// Handshake and data bundle between the EX stage and the iterative mul/div unit.
interface core_ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             accept;
  logic             flush;
  logic             op_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output op_valid, op, in1, in2, accept, flush,
    input  op_ready, out, busy
  );

  modport slave (
    input  op_valid, op, in1, in2, accept, flush,
    output op_ready, out, busy
  );
endinterface

// File: rtl/core_ex_muldiv.sv
// RV32M multiply/divide sequencer: one radix-2 shift-add/subtract datapath shared
// by multiply and restoring divide, sequenced IDLE -> CALC -> DONE.
module core_ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rest,
  core_ex_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] MINV     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   out_q, out_d;

  // Operand preparation
  logic             is_div, sgn1, sgn2, s1, s2, div_zero, div_ovf;
  logic [WIDTH-1:0] abs1, abs2;

  assign is_div   = bus.op[2];
  assign sgn1     = (bus.op == 3'd0) || (bus.op == 3'd1) || (bus.op == 3'd2) ||
                    (bus.op == 3'd4) || (bus.op == 3'd6);
  assign sgn2     = (bus.op == 3'd0) || (bus.op == 3'd1) ||
                    (bus.op == 3'd4) || (bus.op == 3'd6);
  assign s1       = sgn1 & bus.in1[WIDTH-1];
  assign s2       = sgn2 & bus.in2[WIDTH-1];
  assign abs1     = s1 ? -bus.in1 : bus.in1;
  assign abs2     = s2 ? -bus.in2 : bus.in2;
  assign div_zero = is_div && (bus.in2 == '0);
  assign div_ovf  = is_div && !bus.op[0] && (bus.in1 == MINV) && (bus.in2 == '1);

  // One datapath iteration; acc holds product {hi,lo} or {remainder,quotient}
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] mul_next, div_next, iter, prod_fix;
  logic [WIDTH-1:0]   div_sel, calc_res;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign diff     = {1'b0, rem_sh} - {2'b00, opb_q};
  assign div_next = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
  assign iter     = op_q[2] ? div_next : mul_next;
  assign prod_fix = neg_q ? -iter : iter;
  assign div_sel  = op_q[1] ? iter[2*WIDTH-1:WIDTH] : iter[WIDTH-1:0];

  always_comb begin
    calc_res = '0;
    if (!op_q[2]) begin
      calc_res = (op_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
    end else begin
      calc_res = neg_q ? -div_sel : div_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    out_d   = out_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.op_valid) begin
            if (div_zero) begin
              out_d   = bus.op[1] ? bus.in1 : '1;
              state_d = DONE;
            end else if (div_ovf) begin
              out_d   = bus.op[1] ? '0 : MINV;
              state_d = DONE;
            end else begin
              op_d    = bus.op;
              cnt_d   = CNT_LOAD;
              // Multiplier/dividend sits in the low half; the other operand is added/subtracted
              acc_d   = {{WIDTH{1'b0}}, (is_div ? abs1 : abs2)};
              opb_d   = is_div ? abs2 : abs1;
              neg_d   = (is_div && bus.op[1]) ? s1 : (s1 ^ s2);
              state_d = CALC;
            end
          end
        end
        CALC: begin
          acc_d = iter;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_d   = calc_res;
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.accept) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign bus.op_ready = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.out      = out_q;
endmodule

// File: tb/tb_core_ex_muldiv.sv
// Scoreboard bench for core_ex_muldiv: a 64-bit arithmetic RV32M model feeds a
// queue of expected results, popped by a monitor whenever a result is accepted.
module tb_core_ex_muldiv;
  logic clk;
  logic rest;
  int   total;
  int   bad;
  logic [31:0] last_out;
  logic [31:0] sb[$];

  core_ex_muldiv_if #(.WIDTH(32)) bus ();
  core_ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rest(rest), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb_, p;
    longint unsigned ua, ub, up;
    sa = longint'(signed'(a));
    sb_ = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (sa == -64'sd2147483648 && sb_ == -64'sd1) return 32'h8000_0000;
        p = sa / sb_; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (sa == -64'sd2147483648 && sb_ == -64'sd1) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    if (o >= 3'd4 && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // Monitor: a result is consumed whenever DONE meets accept at the coming edge
  always @(negedge clk) begin
    if (rest && bus.op_ready && bus.accept) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h want none", bus.out);
      end else begin
        check("result", bus.out, sb.pop_front());
      end
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op       = o;
    bus.in1      = a;
    bus.in2      = b;
    bus.op_valid = 1'b1;
  endtask

  // Issue one operation from an IDLE cycle; returns in the IDLE cycle after acceptance
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] exp;
    int n;
    exp = ref_model(o, a, b);
    sb.push_back(exp);
    bus.accept = (stall == 0);
    start_op(o, a, b);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      n++;
      if (k == 0) check("busy_start", {31'd0, bus.busy}, 32'd1);
      if (bus.op_ready) break;
    end
    check("latency", 32'(n), 32'(exp_latency(o, a, b)));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_ready", {31'd0, bus.op_ready}, 32'd1);
      check("stall_out", bus.out, exp);
    end
    bus.accept = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    last_out = exp;
  endtask

  initial begin
    bit seen;
    total = 0;
    bad = 0;
    last_out = '0;
    rest = 1'b0;
    bus.op_valid = 1'b0;
    bus.op = '0;
    bus.in1 = '0;
    bus.in2 = '0;
    bus.accept = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, bus.op_ready}, 32'd0);
    check("reset_out", bus.out, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    rest = 1'b1;
    @(posedge clk); #1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFA, 0);
    do_op(3'd3, 32'd7, 32'hFFFF_FFFA, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd5, 32'h1357_9BDF, 32'd0, 0);
    do_op(3'd6, 32'h0000_1234, 32'd0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Stall in DONE, then back-to-back start after exactly one IDLE cycle
    do_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 10);
    check("idle_gap_busy", {31'd0, bus.busy}, 32'd0);
    do_op(3'd7, 32'hDEAD_BEEF, 32'd12345, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 0);
    end

    // Flush at CALC cycle 10
    bus.accept = 1'b1;
    start_op(3'd0, 32'd99, 32'd77);
    repeat (10) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_out", bus.out, last_out);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.op_ready) seen = 1'b1;
    end
    check("flush_no_ready", {31'd0, seen}, 32'd0);

    // Flush on the final CALC cycle must not write the result
    start_op(3'd5, 32'd1000, 32'd3);
    repeat (32) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    check("flush_last_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_last_out", bus.out, last_out);
    check("flush_last_ready", {31'd0, bus.op_ready}, 32'd0);

    // Flush in IDLE beats a pending op_valid
    start_op(3'd0, 32'd3, 32'd4);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    check("flush_idle_busy", {31'd0, bus.busy}, 32'd0);

    do_op(3'd0, 32'd11, 32'd13, 0);

    // Asynchronous reset at CALC cycle 5
    start_op(3'd1, 32'hCAFE_F00D, 32'h1234_5678);
    repeat (5) @(posedge clk);
    #1;
    rest = 1'b0;
    #1;
    check("areset_ready", {31'd0, bus.op_ready}, 32'd0);
    check("areset_out", bus.out, 32'd0);
    check("areset_busy", {31'd0, bus.busy}, 32'd0);
    bus.op_valid = 1'b0;
    @(posedge clk); #1;
    rest = 1'b1;
    last_out = '0;
    @(posedge clk); #1;
    check("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    check("post_reset_out", bus.out, 32'd0);

    do_op(3'd6, 32'hFFFF_FF00, 32'd7, 0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
